health_tracker: RTL

HEALTH_TRACKER -- requirements
Module: health_tracker

---
 rtl/health_tracker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/health_tracker.sv
// rtl/health_tracker.sv - per-fighter health/invulnerability/death tracker; optional regen via HEALTH_REGEN_EN
// Two identical fighter FSMs (ALIVE/INVULN/DEAD) share the stage inputs; all outputs are registered.

module health_fighter #(
  parameter int MAX_HP       = 100,
  parameter int HP_W         = 7,
  parameter int DMG_W        = 4,
  parameter int IFRAMES      = 30,
  parameter int DEAD_HOLD    = 60,
  parameter int REGEN_PERIOD = 60
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start_l,
  input  logic             game_l,
  input  logic             hit,
  input  logic [DMG_W-1:0] dmg,
  output logic [HP_W-1:0]  hp,
  output logic             dead,
  output logic             iframe
);

  localparam int CNT_MAX = (IFRAMES > DEAD_HOLD) ? IFRAMES : DEAD_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CMP_W   = (HP_W > DMG_W) ? HP_W : DMG_W;
  localparam logic [HP_W-1:0]  FULL_HP   = HP_W'(MAX_HP);
  localparam logic [CNT_W-1:0] IF_LAST   = CNT_W'(IFRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DEAD_HOLD - 1);

  if (MAX_HP >= (1 << HP_W) || IFRAMES < 1 || DEAD_HOLD < 1 || REGEN_PERIOD < 1) begin : g_bad_cfg
    $error("health_fighter: invalid parameter set");
  end

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} fsm_t;

  fsm_t             state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dead_q, dead_d;
  logic             iframe_q, iframe_d;
  logic             hit_ok, lethal;

`ifdef HEALTH_REGEN_EN
  localparam int RG_W = $clog2(REGEN_PERIOD + 1);
  localparam logic [RG_W-1:0] RG_LAST = RG_W'(REGEN_PERIOD - 1);
  logic [RG_W-1:0] regen_q, regen_d;
`endif

  assign hit_ok = hit && game_l && (dmg != '0);
  assign lethal = CMP_W'(dmg) >= CMP_W'(hp_q);

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    dead_d   = dead_q;
    iframe_d = iframe_q;
`ifdef HEALTH_REGEN_EN
    regen_d  = regen_q;
`endif
    if (start_l) begin
      state_d  = ALIVE;
      hp_d     = FULL_HP;
      cnt_d    = '0;
      dead_d   = 1'b0;
      iframe_d = 1'b0;
`ifdef HEALTH_REGEN_EN
      regen_d  = '0;
`endif
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit_ok) begin
            cnt_d = '0;
`ifdef HEALTH_REGEN_EN
            regen_d = '0;
`endif
            if (lethal) begin
              state_d = DEAD;
              hp_d    = '0;
              dead_d  = 1'b1;
            end else begin
              state_d  = INVULN;
              hp_d     = hp_q - HP_W'(dmg);
              iframe_d = 1'b1;
            end
          end
`ifdef HEALTH_REGEN_EN
          else if (game_l && hp_q < FULL_HP) begin
            if (regen_q == RG_LAST) begin
              hp_d    = hp_q + HP_W'(1);
              regen_d = '0;
            end else begin
              regen_d = regen_q + RG_W'(1);
            end
          end
`endif
        end
        INVULN: begin
          if (game_l) begin
            if (cnt_q == IF_LAST) begin
              state_d  = ALIVE;
              cnt_d    = '0;
              iframe_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DEAD: begin
          // The hold only runs once the stage has left the fight.
          if (!game_l) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = ALIVE;
              hp_d    = FULL_HP;
              cnt_d   = '0;
              dead_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ALIVE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ALIVE;
      hp_q     <= FULL_HP;
      cnt_q    <= '0;
      dead_q   <= 1'b0;
      iframe_q <= 1'b0;
`ifdef HEALTH_REGEN_EN
      regen_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      dead_q   <= dead_d;
      iframe_q <= iframe_d;
`ifdef HEALTH_REGEN_EN
      regen_q  <= regen_d;
`endif
    end
  end

  assign hp     = hp_q;
  assign dead   = dead_q;
  assign iframe = iframe_q;

endmodule

module health_tracker #(
  parameter int MAX_HP       = 100,
  parameter int HP_W         = 7,
  parameter int DMG_W        = 4,
  parameter int IFRAMES      = 30,
  parameter int DEAD_HOLD    = 60,
  parameter int REGEN_PERIOD = 60
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start_l,
  input  logic             game_l,
  input  logic             player_hit,
  input  logic             npc_hit,
  input  logic [DMG_W-1:0] player_dmg,
  input  logic [DMG_W-1:0] npc_dmg,
  output logic [HP_W-1:0]  player_hp,
  output logic [HP_W-1:0]  npc_hp,
  output logic             Player_Dead,
  output logic             NPC_Dead,
  output logic             player_iframe,
  output logic             npc_iframe
);

  health_fighter #(
    .MAX_HP(MAX_HP), .HP_W(HP_W), .DMG_W(DMG_W),
    .IFRAMES(IFRAMES), .DEAD_HOLD(DEAD_HOLD), .REGEN_PERIOD(REGEN_PERIOD)
  ) u_player (
    .Clk(Clk), .Reset(Reset), .start_l(start_l), .game_l(game_l),
    .hit(player_hit), .dmg(player_dmg),
    .hp(player_hp), .dead(Player_Dead), .iframe(player_iframe)
  );

  health_fighter #(
    .MAX_HP(MAX_HP), .HP_W(HP_W), .DMG_W(DMG_W),
    .IFRAMES(IFRAMES), .DEAD_HOLD(DEAD_HOLD), .REGEN_PERIOD(REGEN_PERIOD)
  ) u_npc (
    .Clk(Clk), .Reset(Reset), .start_l(start_l), .game_l(game_l),
    .hit(npc_hit), .dmg(npc_dmg),
    .hp(npc_hp), .dead(NPC_Dead), .iframe(npc_iframe)
  );

endmodule
